ext_bus_arbiter: RTL

Two-master arbiter and transfer sequencer for the shared external bus. It sits between the bus masters and the external bus interface. Master 0 is the memory-manager external path and master 1 is the debug/DMA loader. Each transfer is granted round-robin, its request fields are latched and held stable on the bus until the slave signals ready or a timeout expires, and a one-cycle completion pulse with read data goes back to the owning master.

---
 rtl/ext_bus_arbiter_pkg.sv | 29 ++
 rtl/ext_bus_arbiter_if.sv | 52 +++++
 rtl/ext_bus_arbiter_timeout_ctr.sv | 32 +++
 rtl/ext_bus_arbiter.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/ext_bus_arbiter_pkg.sv
// Shared types and encodings for the external bus arbiter: FSM states, transfer
// size codes and small helpers used by the arbiter and its timeout counter.
package ext_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } arb_state_e;

    localparam logic [1:0] SIZE_BYTE    = 2'b00;
    localparam logic [1:0] SIZE_HALF    = 2'b01;
    localparam logic [1:0] SIZE_WORD    = 2'b10;
    localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

    function automatic logic size_is_legal(input logic [1:0] size);
        case (size)
            SIZE_BYTE, SIZE_HALF, SIZE_WORD: return 1'b1;
            SIZE_ILLEGAL:                    return 1'b0;
            default:                         return 1'b0;
        endcase
    endfunction

    // A single-cycle timeout still needs a one-bit counter.
    function automatic int ctr_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/ext_bus_arbiter_if.sv
// Bundle of the two master request/response ports and the external bus side.
// The arbiter uses the slave modport; whoever drives masters and the bus slave uses master.
interface ext_bus_arbiter_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int EXT_ADDR_WIDTH = 16
);
    logic                      m0_req;
    logic                      m0_we;
    logic [1:0]                m0_size;
    logic [EXT_ADDR_WIDTH-1:0] m0_addr;
    logic [DATA_WIDTH-1:0]     m0_wdata;
    logic [DATA_WIDTH-1:0]     m0_rdata;
    logic                      m0_done;
    logic                      m0_err;

    logic                      m1_req;
    logic                      m1_we;
    logic [1:0]                m1_size;
    logic [EXT_ADDR_WIDTH-1:0] m1_addr;
    logic [DATA_WIDTH-1:0]     m1_wdata;
    logic [DATA_WIDTH-1:0]     m1_rdata;
    logic                      m1_done;
    logic                      m1_err;

    logic                      o_bus_en;
    logic                      o_bus_we;
    logic [1:0]                o_bus_size;
    logic [EXT_ADDR_WIDTH-1:0] o_bus_addr;
    logic [DATA_WIDTH-1:0]     bus_wdata;
    logic [DATA_WIDTH-1:0]     bus_rdata;
    logic                      bus_data_o_en;
    logic                      i_bus_rdy;

    modport slave (
        input  m0_req, m0_we, m0_size, m0_addr, m0_wdata,
        output m0_rdata, m0_done, m0_err,
        input  m1_req, m1_we, m1_size, m1_addr, m1_wdata,
        output m1_rdata, m1_done, m1_err,
        output o_bus_en, o_bus_we, o_bus_size, o_bus_addr, bus_wdata, bus_data_o_en,
        input  bus_rdata, i_bus_rdy
    );

    modport master (
        output m0_req, m0_we, m0_size, m0_addr, m0_wdata,
        input  m0_rdata, m0_done, m0_err,
        output m1_req, m1_we, m1_size, m1_addr, m1_wdata,
        input  m1_rdata, m1_done, m1_err,
        input  o_bus_en, o_bus_we, o_bus_size, o_bus_addr, bus_wdata, bus_data_o_en,
        output bus_rdata, i_bus_rdy
    );

endinterface

// File: rtl/ext_bus_arbiter_timeout_ctr.sv
// Up-counter that measures how long a bus cycle has waited for ready; expired is
// high during the last permitted XFER cycle.
module bus_timeout_ctr
    import ext_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int            CW   = ctr_width(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count;

    // Saturate at LAST so a stalled state machine can never wrap the count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != LAST)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = enable && (count == LAST);

endmodule

// File: rtl/ext_bus_arbiter.sv
// Two-master round-robin arbiter and transfer sequencer for the shared external bus.
// The granted request is latched and held on the bus until ready or timeout.
//
// state | meaning
// ------+-------------------------------------------------------
// IDLE  | no transfer active; requests sampled and granted
// XFER  | bus cycle in progress, fields driven from latches
// DONE  | one-cycle completion pulse to the owning master
module ext_bus_arbiter
    import ext_arb_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int EXT_ADDR_WIDTH = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic             clk,
    input  logic             reset,
    ext_bus_arbiter_if.slave bus
);
    arb_state_e state;
    arb_state_e state_nxt;

    logic                      last_grant;
    logic                      grant_sel;
    logic                      grant_en;
    logic                      rdy_hit;
    logic                      tmo_hit;
    logic                      tmo_expired;
    logic                      xfer_active;

    logic                      sel_we;
    logic [1:0]                sel_size;
    logic [EXT_ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0]     sel_wdata;

    logic                      we_q;
    logic [1:0]                size_q;
    logic [EXT_ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0]     wdata_q;
    logic                      err_q;
    logic [DATA_WIDTH-1:0]     rdata0_q;
    logic [DATA_WIDTH-1:0]     rdata1_q;

    // On a tie the master that did not win last time is granted; last_grant
    // doubles as the owner of the transfer in flight.
    assign grant_sel = (bus.m0_req && bus.m1_req) ? ~last_grant : bus.m1_req;

    assign sel_we    = grant_sel ? bus.m1_we    : bus.m0_we;
    assign sel_size  = grant_sel ? bus.m1_size  : bus.m0_size;
    assign sel_addr  = grant_sel ? bus.m1_addr  : bus.m0_addr;
    assign sel_wdata = grant_sel ? bus.m1_wdata : bus.m0_wdata;

    assign xfer_active = (state == XFER);

    bus_timeout_ctr #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout_ctr (
        .clk    (clk),
        .reset  (reset),
        .clear  (!xfer_active),
        .enable (xfer_active),
        .expired(tmo_expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        grant_en  = 1'b0;
        rdy_hit   = 1'b0;
        tmo_hit   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.m0_req || bus.m1_req) begin
                    grant_en  = 1'b1;
                    state_nxt = size_is_legal(sel_size) ? XFER : DONE;
                end
            end
            XFER: begin
                // Ready beats a simultaneous timeout.
                if (bus.i_bus_rdy) begin
                    rdy_hit   = 1'b1;
                    state_nxt = DONE;
                end else if (tmo_expired) begin
                    tmo_hit   = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= 1'b1;
            we_q       <= 1'b0;
            size_q     <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            err_q      <= 1'b0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
        end else begin
            if (grant_en) begin
                last_grant <= grant_sel;
                we_q       <= sel_we;
                size_q     <= sel_size;
                addr_q     <= sel_addr;
                wdata_q    <= sel_wdata;
                err_q      <= !size_is_legal(sel_size);
            end
            if (rdy_hit) begin
                err_q <= 1'b0;
                if (!we_q) begin
                    if (last_grant) begin
                        rdata1_q <= bus.bus_rdata;
                    end else begin
                        rdata0_q <= bus.bus_rdata;
                    end
                end
            end
            if (tmo_hit) begin
                err_q <= 1'b1;
            end
        end
    end

    assign bus.o_bus_en      = xfer_active;
    assign bus.o_bus_we      = we_q;
    assign bus.o_bus_size    = size_q;
    assign bus.o_bus_addr    = addr_q;
    assign bus.bus_wdata     = wdata_q;
    assign bus.bus_data_o_en = xfer_active && we_q;

    assign bus.m0_done  = (state == DONE) && !last_grant;
    assign bus.m1_done  = (state == DONE) && last_grant;
    assign bus.m0_err   = bus.m0_done && err_q;
    assign bus.m1_err   = bus.m1_done && err_q;
    assign bus.m0_rdata = rdata0_q;
    assign bus.m1_rdata = rdata1_q;

endmodule
